// File: rtl/uio_bus_arbiter_pkg.sv
// rtl/uio_bus_arbiter_pkg.sv - shared types and pad constants for the uio bus arbiter
package uio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  typedef logic req_idx_t;

  localparam int              UIO_W  = 8;
  localparam logic [UIO_W-1:0] OE_OUT = 8'hFF;
  localparam logic [UIO_W-1:0] OE_IN  = 8'h00;

endpackage

// File: rtl/uio_rr_picker.sv
// rtl/uio_rr_picker.sv - two-way round-robin select between level requests
module uio_rr_picker
  import uio_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output req_idx_t   winner,
  output logic       valid
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - round-robin owner of the uio pad group with bursts and turnaround gaps
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [UIO_W-1:0] wdata0,
  input  logic [UIO_W-1:0] wdata1,
  output logic [1:0]       grant,
  output logic [UIO_W-1:0] rdata,
  output logic [1:0]       rvalid,
  output logic             busy,
  input  logic [UIO_W-1:0] uio_in,
  output logic [UIO_W-1:0] uio_out,
  output logic [UIO_W-1:0] uio_oe
);

  localparam logic [3:0] MAX_B     = 4'(MAX_BURST);
  localparam logic [1:0] TURN_INIT = 2'(TURN_CYCLES);

  state_t     state;
  req_idx_t   winner;
  req_idx_t   last;
  logic       dir_q;
  logic [3:0] beat_cnt;
  logic [1:0] turn_cnt;
  req_idx_t   pick;
  logic       pick_valid;

  uio_rr_picker u_picker (
    .req    (req),
    .last   (last),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      winner   <= 1'b0;
      last     <= 1'b1;
      dir_q    <= 1'b0;
      beat_cnt <= 4'd0;
      turn_cnt <= 2'd0;
      rdata    <= '0;
      rvalid   <= 2'b00;
    end else begin
      rvalid <= 2'b00;
      if (!ena) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              winner   <= pick;
              last     <= pick;
              dir_q    <= dir[pick];
              beat_cnt <= 4'd0;
              turn_cnt <= TURN_INIT;
              state    <= (TURN_INIT == 2'd0) ? OWN : TURN;
            end
          end
          TURN: begin
            turn_cnt <= turn_cnt - 2'd1;
            if (turn_cnt == 2'd1) state <= OWN;
          end
          OWN: begin
            // A cycle without the owner's request ends the burst and is not a beat.
            if (!req[winner]) begin
              state <= IDLE;
            end else begin
              if (beat_cnt != MAX_B) beat_cnt <= beat_cnt + 4'd1;
              if (!dir_q) begin
                rdata          <= uio_in;
                rvalid[winner] <= 1'b1;
              end
              if (beat_cnt + 4'd1 >= MAX_B) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pad controls decode only registered state, so uio_oe never follows an input directly.
  always_comb begin
    busy    = (state != IDLE);
    grant   = 2'b00;
    uio_oe  = OE_IN;
    uio_out = '0;
    if (state == OWN) begin
      grant[winner] = 1'b1;
      if (dir_q) begin
        uio_oe  = OE_OUT;
        uio_out = winner ? wdata1 : wdata0;
      end
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb/tb_uio_bus_arbiter.sv - self-checking bench for uio_bus_arbiter
module tb_uio_bus_arbiter;

  localparam int MAXB = 4;
  localparam int TURN = 1;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [1:0] req, dir, grant, rvalid;
  logic [7:0] wdata0, wdata1, rdata, uio_in, uio_out, uio_oe;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: who owns the pads, how long until they do, beats taken
  int         m_own, m_gap, m_next, m_beats, m_last;
  logic       m_dirq;
  logic [7:0] m_rdata;
  logic [1:0] m_rvalid;

  logic [7:0] last_oe, last_out, last_grant, last_rvalid, last_rdata;

  uio_bus_arbiter #(.MAX_BURST(MAXB), .TURN_CYCLES(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir),
    .wdata0(wdata0), .wdata1(wdata1), .grant(grant), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_gap = 0; m_next = 0; m_beats = 0; m_last = 1;
    m_dirq = 1'b0; m_rdata = 8'h00; m_rvalid = 2'b00;
  endtask

  task automatic model_advance();
    logic [1:0] nrv;
    int w;
    nrv = 2'b00;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) begin
      m_own = -1; m_gap = 0;
    end else if (m_own >= 0) begin
      if (req[m_own]) begin
        m_beats++;
        if (!m_dirq) begin
          m_rdata = uio_in;
          nrv[m_own] = 1'b1;
        end
        if (m_beats >= MAXB) m_own = -1;
      end else begin
        m_own = -1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_own = m_next; m_beats = 0;
      end
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
      m_last = w;
      m_dirq = dir[w];
      m_beats = 0;
      if (TURN == 0) m_own = w;
      else begin
        m_gap = TURN; m_next = w;
      end
    end
    m_rvalid = nrv;
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later, then the model moves on.
  task automatic step();
    logic [7:0] e_grant, e_oe, e_out;
    #1;
    e_grant = (m_own < 0) ? 8'h00 : ((m_own == 1) ? 8'h02 : 8'h01);
    e_oe    = (m_own >= 0 && m_dirq) ? 8'hFF : 8'h00;
    e_out   = (m_own >= 0 && m_dirq) ? ((m_own == 1) ? wdata1 : wdata0) : 8'h00;
    chk("grant", {6'b0, grant}, e_grant);
    chk("uio_oe", uio_oe, e_oe);
    chk("uio_out", uio_out, e_out);
    chk("busy", {7'b0, busy}, {7'b0, (m_own >= 0) || (m_gap > 0)});
    chk("rdata", rdata, m_rdata);
    chk("rvalid", {6'b0, rvalid}, {6'b0, m_rvalid});
    last_oe = uio_oe; last_out = uio_out; last_grant = {6'b0, grant};
    last_rvalid = {6'b0, rvalid}; last_rdata = rdata;
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] seq2 [9]  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
  logic [7:0] seq3 [12] = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11,
                            8'h00, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22};

  initial begin
    int pulses;
    rst_n = 1'b0; ena = 1'b1; req = 2'b00; dir = 2'b00;
    wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;
    @(negedge clk);
    model_reset();

    // reset held with both requesting, then first free cycle
    req = 2'b11;
    step(); step();
    chk("t1_grant_in_reset", last_grant, 8'h00);
    rst_n = 1'b1; req = 2'b00;
    step();
    chk("t1_oe_after_reset", last_oe, 8'h00);

    // write burst by requester 0, then re-grant after the gap
    do_reset();
    req = 2'b01; dir = 2'b01; wdata0 = 8'hA5;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t2_oe_%0d", i), last_oe, seq2[i]);
      if (i == 2) chk("t2_out", last_out, 8'hA5);
    end

    // contention: both write, bursts alternate starting with requester 0
    req = 2'b11; dir = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22;
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t3_out_%0d", i), last_out, seq3[i]);
    end

    // read: requester 1 samples 3C for three beats then releases
    req = 2'b00; dir = 2'b00; uio_in = 8'h3C;
    do_reset();
    req = 2'b10;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_rvalid == 8'h02) pulses++;
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_rvalid == 8'h02) pulses++;
    end
    chk("t4_pulses", 8'(pulses), 8'd3);
    chk("t4_rdata", last_rdata, 8'h3C);

    // early release after two beats, then reset in the middle of a write
    do_reset();
    req = 2'b01; dir = 2'b01; wdata0 = 8'h5A;
    step(); step(); step(); step();
    req = 2'b00;
    step(); step();
    req = 2'b01;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t5_grant_after_rst", last_grant, 8'h00);
    chk("t5_oe_after_rst", last_oe, 8'h00);

    // ena drop during requester 0 ownership keeps the pointer
    req = 2'b00;
    do_reset();
    req = 2'b01;
    step(); step(); step();
    ena = 1'b0;
    step();
    ena = 1'b1; req = 2'b11;
    last_grant = 8'h00;
    for (int i = 0; i < 6 && last_grant == 8'h00; i++) step();
    chk("t6_regrant", last_grant, 8'h02);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      ena    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom);
      dir    = 2'($urandom);
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      uio_in = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
